bus_err_arbiter: RTL and testbench
==================================

# bus_err_arbiter

Drains up to `NumUnits` bare bus error units through one report channel. The block watches each unit's error interrupt, picks a pending unit round-robin and pops one entry from that unit's error FIFO. It holds the captured entry on a valid/ready report port for the register or debug front end. It also keeps a saturating report counter and a sticky overflow flag, and drives one aggregated interrupt.

## Interface
Parameters:
- `NumUnits`, 4, number of error units served; 1..32.
- `AddrWidth`, 48, error address width.
- `MetaDataWidth`, 1, metadata width.
- `ErrBits`, 3, error code width.
- `CntWidth`, 16, report counter width.

Ports:
- `clk_i`  in  1  clock; the only clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `unit_irq_i`  in  NumUnits  per-unit "error FIFO non-empty".
- `unit_code_i`  in  NumUnits×ErrBits  head-of-FIFO error code.
- `unit_addr_i`  in  NumUnits×AddrWidth  head-of-FIFO address.
- `unit_meta_i`  in  NumUnits×MetaDataWidth  head-of-FIFO metadata.
- `unit_overflow_i`  in  NumUnits  per-unit overflow indication.
- `unit_pop_o`  out  NumUnits  one-hot, single-cycle pop pulse.
- `rpt_valid_o`  out  1  report holding register valid.
- `rpt_ready_i`  in  1  consumer accepts the report.
- `rpt_unit_o`  out  idx_width(NumUnits)  source unit index.
- `rpt_code_o` / `rpt_addr_o` / `rpt_meta_o`  out  ErrBits / AddrWidth / MetaDataWidth  captured entry.
- `rpt_time_o`  out  32  capture timestamp; see Configuration.
- `rpt_count_o`  out  CntWidth  saturating count of accepted reports.
- `count_clr_i`  in  1  clears `rpt_count_o` and the sticky overflow flag.
- `overflow_o`  out  1  sticky OR of `unit_overflow_i`.
- `irq_o`  out  1  `rpt_valid_o | overflow_o`.

## Operation
FSM states are `IDLE` and `HOLD`. Reset enters `IDLE`.

`IDLE`:
- If `|unit_irq_i` is high, grant one unit by round-robin, starting at priority pointer `ptr`.
- In the same cycle, pulse `unit_pop_o[g]`.
- At the clock edge, capture `unit_code_i[g]`, `unit_addr_i[g]`, `unit_meta_i[g]` and `g` into the holding register.
- Set `ptr` to `(g+1) mod NumUnits`, then go to `HOLD`.
- If no unit is pending, stay in `IDLE` and leave `ptr` unchanged.

`HOLD`:
- `rpt_valid_o` is 1. Holding-register contents are stable until the handshake.
- On `rpt_valid_o & rpt_ready_i`, return to `IDLE` and increment `rpt_count_o`. The counter saturates at all-ones.
- No pops occur in `HOLD`.

Counter and overflow:
- `count_clr_i` has priority over an increment in the same cycle; the counter becomes 0.
- `overflow_o` sets on any `unit_overflow_i` bit.
- If set and clear arrive in the same cycle, set wins.

## Timing
- All outputs reset to 0: `rpt_*`, `unit_pop_o`, `rpt_count_o`, `overflow_o`, `irq_o`. `ptr` resets to 0.
- `unit_pop_o` is combinational from state and `unit_irq_i`. All other outputs are registered.
- Latency from `unit_irq_i` rising to `rpt_valid_o` is 1 cycle.
- Throughput is at most one report every 2 cycles. This is required: a non-fall-through FIFO updates `empty`/`data` one cycle after a pop, and `HOLD` absorbs that cycle.
- `rpt_ready_i` may be high before `rpt_valid_o`. With `rpt_ready_i` held high, the pattern is `IDLE`, `HOLD`, `IDLE`, `HOLD`, …
- `unit_irq_i` dropping while in `HOLD` has no effect. `unit_irq_i` must be valid in `IDLE` and data must be stable during the pop cycle.
- `NumUnits` = 1: the arbiter degenerates and `ptr` stays 0.
- Reset mid-`HOLD` discards the held entry. It is not re-popped, so it is lost.

## Configuration
- `BUS_ERR_ARB_TIMESTAMP_EN` defined:
  - A 32-bit free-running cycle counter runs from reset and wraps at 2^32.
  - Its value at the capture edge is latched to `rpt_time_o`.
- `BUS_ERR_ARB_TIMESTAMP_EN` undefined:
  - No counter is built.
  - `rpt_time_o` is tied to `'0`.
  - The port stays present.

## Structure
- Package `bus_err_arb_pkg` holds:
  - the state enum `arb_state_e {IDLE, HOLD}`;
  - `localparam` `TsWidth = 32`;
  - the parameterised report-struct helper used for the holding register.
- Sub-module `bus_err_rr_pick`:
  - Combinational round-robin picker.
  - Inputs: request vector and `ptr`.
  - Outputs: `gnt_valid` and binary `gnt_idx`.
  - Implemented with a doubled-vector search from `ptr`.

## Test plan
- Single error: unit 2 asserts irq with addr `0x1000`, code 3, and `rpt_ready_i`=1 → `unit_pop_o`=`0b0100` for one cycle; the next cycle shows `rpt_valid_o`=1, unit 2, addr `0x1000`, code 3; `rpt_count_o`=1.
- Fairness: all 4 units pending with `ptr`=0 and ready high → grant order 0,1,2,3,0, one grant every 2 cycles.
- Backpressure: `rpt_ready_i`=0 for 5 cycles during `HOLD` → outputs stable, no pops; ready=1 → return to `IDLE`, count increments once.
- Saturation and clear: `CntWidth`=2 with 5 accepted reports → count 3. `count_clr_i` on the same cycle as a handshake → count 0.
- Overflow: pulse `unit_overflow_i[1]` → `overflow_o` and `irq_o`=1 from the next cycle; `count_clr_i` → both clear, provided no report is pending.
- Reset mid-`HOLD`: assert `rst_ni`=0 asynchronously → all outputs 0 immediately; after release, FSM in `IDLE` and `ptr`=0.

Source files
------------

// File: rtl/bus_err_arbiter_pkg.sv
// Shared types and helpers for the bus error arbiter.
// Optional feature macro: BUS_ERR_ARB_TIMESTAMP_EN (capture timestamp).
package bus_err_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   localparam int unsigned TsWidth = 32;

   // Index width for n units; a single unit still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of the flattened report holding register.
   function automatic int unsigned rpt_bits(input int unsigned idx_w,
                                            input int unsigned err_bits,
                                            input int unsigned addr_w,
                                            input int unsigned meta_w);
      return idx_w + err_bits + addr_w + meta_w;
   endfunction

endpackage

// File: rtl/bus_err_arbiter_if.sv
// Unit-side and report-side signals of the bus error arbiter.
// master: the arbiter; slave: the error units plus the report consumer.
interface bus_err_arbiter_if
   import bus_err_arb_pkg::*;
#(
   parameter int unsigned NumUnits      = 4,
   parameter int unsigned AddrWidth     = 48,
   parameter int unsigned MetaDataWidth = 1,
   parameter int unsigned ErrBits       = 3,
   parameter int unsigned CntWidth      = 16
);
   localparam int unsigned IdxW = idx_width(NumUnits);

   logic [NumUnits-1:0]                    unit_irq_i;
   logic [NumUnits-1:0][ErrBits-1:0]       unit_code_i;
   logic [NumUnits-1:0][AddrWidth-1:0]     unit_addr_i;
   logic [NumUnits-1:0][MetaDataWidth-1:0] unit_meta_i;
   logic [NumUnits-1:0]                    unit_overflow_i;
   logic [NumUnits-1:0]                    unit_pop_o;
   logic                                   rpt_valid_o;
   logic                                   rpt_ready_i;
   logic [IdxW-1:0]                        rpt_unit_o;
   logic [ErrBits-1:0]                     rpt_code_o;
   logic [AddrWidth-1:0]                   rpt_addr_o;
   logic [MetaDataWidth-1:0]               rpt_meta_o;
   logic [TsWidth-1:0]                     rpt_time_o;
   logic [CntWidth-1:0]                    rpt_count_o;
   logic                                   count_clr_i;
   logic                                   overflow_o;
   logic                                   irq_o;

   modport master (
      input  unit_irq_i, unit_code_i, unit_addr_i, unit_meta_i, unit_overflow_i,
      input  rpt_ready_i, count_clr_i,
      output unit_pop_o, rpt_valid_o, rpt_unit_o, rpt_code_o, rpt_addr_o,
      output rpt_meta_o, rpt_time_o, rpt_count_o, overflow_o, irq_o
   );

   modport slave (
      output unit_irq_i, unit_code_i, unit_addr_i, unit_meta_i, unit_overflow_i,
      output rpt_ready_i, count_clr_i,
      input  unit_pop_o, rpt_valid_o, rpt_unit_o, rpt_code_o, rpt_addr_o,
      input  rpt_meta_o, rpt_time_o, rpt_count_o, overflow_o, irq_o
   );

endinterface

// File: rtl/bus_err_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i,
// found by searching a doubled request vector rotated by ptr_i.
module bus_err_rr_pick
   import bus_err_arb_pkg::*;
#(
   parameter int unsigned NumUnits = 4,
   localparam int unsigned IdxW    = idx_width(NumUnits)
) (
   input  logic [NumUnits-1:0] req_i,
   input  logic [IdxW-1:0]     ptr_i,
   output logic                gnt_valid_o,
   output logic [IdxW-1:0]     gnt_idx_o
);

   logic [2*NumUnits-1:0] dbl;
   logic [IdxW-1:0]       off;
   logic [IdxW:0]         sum;
   logic                  found;

   // Search the rotated vector, then map the offset back to a unit index.
   always_comb begin
      dbl   = {req_i, req_i} >> ptr_i;
      found = 1'b0;
      off   = '0;
      for (int unsigned k = 0; k < NumUnits; k++) begin
         if (!found && dbl[k]) begin
            found = 1'b1;
            off   = IdxW'(k);
         end
      end
      sum = {1'b0, ptr_i} + {1'b0, off};
      if (sum >= (IdxW+1)'(NumUnits)) begin
         sum = sum - (IdxW+1)'(NumUnits);
      end
      gnt_valid_o = found;
      gnt_idx_o   = sum[IdxW-1:0];
   end

endmodule

// File: rtl/bus_err_arbiter.sv
// Drains several bus error units through one registered report channel.
// Optional feature macro: BUS_ERR_ARB_TIMESTAMP_EN (capture timestamp on rpt_time_o).
module bus_err_arbiter
   import bus_err_arb_pkg::*;
#(
   parameter int unsigned NumUnits      = 4,
   parameter int unsigned AddrWidth     = 48,
   parameter int unsigned MetaDataWidth = 1,
   parameter int unsigned ErrBits       = 3,
   parameter int unsigned CntWidth      = 16
) (
   input logic          clk_i,
   input logic          rst_ni,
   bus_err_arbiter_if.master bus
);

   localparam int unsigned IdxW = idx_width(NumUnits);

   typedef struct packed {
      logic [IdxW-1:0]          unit;
      logic [ErrBits-1:0]       code;
      logic [AddrWidth-1:0]     addr;
      logic [MetaDataWidth-1:0] meta;
   } rpt_t;

   arb_state_e          state_q;
   logic [IdxW-1:0]     ptr_q, ptr_d;
   rpt_t                rpt_q;
   logic                rpt_valid_q, rpt_valid_d;
   logic [CntWidth-1:0] count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                irq_q, irq_d;
   logic                gnt_valid;
   logic [IdxW-1:0]     gnt_idx;
   logic                accept;
   logic                capture;
   logic [NumUnits-1:0] pop;

   bus_err_rr_pick #(.NumUnits(NumUnits)) u_pick (
      .req_i       (bus.unit_irq_i),
      .ptr_i       (ptr_q),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   assign capture = (state_q == IDLE) && gnt_valid;

   // Pointer moves to the unit after the granted one.
   always_comb begin
      ptr_d = ptr_q;
      if (capture) begin
         ptr_d = (gnt_idx == IdxW'(NumUnits - 1)) ? '0 : gnt_idx + IdxW'(1);
      end
   end

   // One-hot pop in the grant cycle; gated by reset so no entry is popped while held in reset.
   always_comb begin
      pop = '0;
      if (rst_ni && capture) begin
         pop[gnt_idx] = 1'b1;
      end
   end

   // Next-state of the registered status outputs.
   always_comb begin
      accept      = rpt_valid_q & bus.rpt_ready_i;
      rpt_valid_d = (state_q == IDLE) ? gnt_valid : ~accept;
      count_d     = count_q;
      if (bus.count_clr_i) begin
         count_d = '0;
      end else if (accept && (count_q != '1)) begin
         count_d = count_q + CntWidth'(1);
      end
      ovf_d = (|bus.unit_overflow_i) | (ovf_q & ~bus.count_clr_i);
      irq_d = rpt_valid_d | ovf_d;
   end

   // Arbitration FSM with the report holding register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         rpt_q       <= '0;
         rpt_valid_q <= 1'b0;
      end else begin
         rpt_valid_q <= rpt_valid_d;
         unique case (state_q)
            IDLE: begin
               if (gnt_valid) begin
                  state_q <= HOLD;
                  ptr_q   <= ptr_d;
                  rpt_q   <= '{unit: gnt_idx,
                               code: bus.unit_code_i[gnt_idx],
                               addr: bus.unit_addr_i[gnt_idx],
                               meta: bus.unit_meta_i[gnt_idx]};
               end
            end
            HOLD: begin
               if (accept) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Report counter, sticky overflow and aggregated interrupt.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         irq_q   <= irq_d;
      end
   end

`ifdef BUS_ERR_ARB_TIMESTAMP_EN
   logic [TsWidth-1:0] ts_q;
   logic [TsWidth-1:0] time_q;

   // Free-running cycle counter, sampled at the capture edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ts_q   <= '0;
         time_q <= '0;
      end else begin
         ts_q <= ts_q + TsWidth'(1);
         if (capture) begin
            time_q <= ts_q;
         end
      end
   end

   assign bus.rpt_time_o = time_q;
`else
   assign bus.rpt_time_o = '0;
`endif

   assign bus.unit_pop_o  = pop;
   assign bus.rpt_valid_o = rpt_valid_q;
   assign bus.rpt_unit_o  = rpt_q.unit;
   assign bus.rpt_code_o  = rpt_q.code;
   assign bus.rpt_addr_o  = rpt_q.addr;
   assign bus.rpt_meta_o  = rpt_q.meta;
   assign bus.rpt_count_o = count_q;
   assign bus.overflow_o  = ovf_q;
   assign bus.irq_o       = irq_q;

endmodule

// File: tb/tb_bus_err_arbiter.sv
// Randomized scoreboard bench for bus_err_arbiter (4 units, 2-bit counter).
module tb_bus_err_arbiter;
   import bus_err_arb_pkg::*;

   localparam int unsigned NU = 4;
   localparam int unsigned AW = 48;
   localparam int unsigned MW = 1;
   localparam int unsigned EB = 3;
   localparam int unsigned CW = 2;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bus_err_arbiter_if #(.NumUnits(NU), .AddrWidth(AW), .MetaDataWidth(MW),
                        .ErrBits(EB), .CntWidth(CW)) bus();

   bus_err_arbiter #(.NumUnits(NU), .AddrWidth(AW), .MetaDataWidth(MW),
                     .ErrBits(EB), .CntWidth(CW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [EB-1:0] code;
      logic [AW-1:0] addr;
      logic [MW-1:0] meta;
   } entry_t;

   typedef struct {
      int unsigned unit;
      entry_t      e;
      logic [31:0] ts;
   } exp_t;

   entry_t fifo[NU][$];
   exp_t   sb[$];
   int     errors = 0;
   int     checks = 0;

   // Reference model state (value the DUT registers should show after the next edge).
   bit          m_hold;
   int unsigned m_ptr, m_count;
   bit          m_ovf;
   logic [31:0] m_cyc;

   int unsigned ready_pct, irq_pct, clr_pct, ovf_pct;
   logic [NU-1:0] ovf_force;
   bit          cur_ready, cur_clr;
   logic [NU-1:0] cur_ovf;
   int unsigned stepno;
   int unsigned glog_unit[$], glog_step[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic entry_t rand_entry();
      entry_t e;
      e.code = EB'($urandom());
      e.addr = AW'({$urandom(), $urandom()});
      e.meta = MW'($urandom());
      return e;
   endfunction

   task automatic drive_inputs();
      logic [NU-1:0]        irq;
      logic [NU-1:0][EB-1:0] code;
      logic [NU-1:0][AW-1:0] addr;
      logic [NU-1:0][MW-1:0] meta;
      for (int u = 0; u < NU; u++) begin
         irq[u]  = fifo[u].size() != 0;
         code[u] = irq[u] ? fifo[u][0].code : '0;
         addr[u] = irq[u] ? fifo[u][0].addr : '0;
         meta[u] = irq[u] ? fifo[u][0].meta : '0;
      end
      cur_ready = $urandom_range(0, 99) < ready_pct;
      cur_clr   = $urandom_range(0, 99) < clr_pct;
      cur_ovf   = ovf_force;
      if ($urandom_range(0, 99) < ovf_pct) cur_ovf[$urandom_range(0, NU-1)] = 1'b1;
      bus.unit_irq_i      = irq;
      bus.unit_code_i     = code;
      bus.unit_addr_i     = addr;
      bus.unit_meta_i     = meta;
      bus.rpt_ready_i     = cur_ready;
      bus.count_clr_i     = cur_clr;
      bus.unit_overflow_i = cur_ovf;
   endtask

   // One cycle: check registered outputs, drive inputs, check pop, advance model.
   task automatic step();
      bit          granted = 0;
      int unsigned g = 0;
      logic [NU-1:0] exp_pop = '0;
      bit          accept;
      exp_t        x;
      @(negedge clk);
      stepno++;
      chk("rpt_valid", 64'(bus.rpt_valid_o), 64'(m_hold));
      chk("rpt_count", 64'(bus.rpt_count_o), 64'(m_count));
      chk("overflow", 64'(bus.overflow_o), 64'(m_ovf));
      chk("irq", 64'(bus.irq_o), 64'(m_hold | m_ovf));
      for (int u = 0; u < NU; u++)
         if (fifo[u].size() < 4 && $urandom_range(0, 99) < irq_pct) fifo[u].push_back(rand_entry());
      drive_inputs();
      #1;
      if (!m_hold) begin
         for (int i = 0; i < NU; i++) begin
            int unsigned u = (m_ptr + i) % NU;
            if (!granted && fifo[u].size() != 0) begin
               granted = 1;
               g = u;
            end
         end
      end
      if (granted) exp_pop[g] = 1'b1;
      chk("unit_pop", 64'(bus.unit_pop_o), 64'(exp_pop));
      accept = m_hold && cur_ready;
      if (granted) begin
         x.unit = g;
         x.e    = fifo[g].pop_front();
         x.ts   = m_cyc;
         sb.push_back(x);
         glog_unit.push_back(g);
         glog_step.push_back(stepno);
         m_hold = 1;
         m_ptr  = (g + 1) % NU;
      end else if (accept) begin
         m_hold = 0;
      end
      if (cur_clr) m_count = 0;
      else if (accept && m_count < CMAX) m_count++;
      m_ovf = (cur_ovf != '0) || (m_ovf && !cur_clr);
      m_cyc++;
   endtask

   // Asynchronous reset: outputs must drop at once; model restarts from zero.
   task automatic do_reset();
      rst_n = 1'b0;
      bus.unit_irq_i      = '0;
      bus.unit_code_i     = '0;
      bus.unit_addr_i     = '0;
      bus.unit_meta_i     = '0;
      bus.unit_overflow_i = '0;
      bus.rpt_ready_i     = 1'b0;
      bus.count_clr_i     = 1'b0;
      #1;
      chk("rst_valid", 64'(bus.rpt_valid_o), 64'd0);
      chk("rst_pop", 64'(bus.unit_pop_o), 64'd0);
      chk("rst_unit", 64'(bus.rpt_unit_o), 64'd0);
      chk("rst_code", 64'(bus.rpt_code_o), 64'd0);
      chk("rst_addr", 64'(bus.rpt_addr_o), 64'd0);
      chk("rst_meta", 64'(bus.rpt_meta_o), 64'd0);
      chk("rst_time", 64'(bus.rpt_time_o), 64'd0);
      chk("rst_count", 64'(bus.rpt_count_o), 64'd0);
      chk("rst_overflow", 64'(bus.overflow_o), 64'd0);
      chk("rst_irq", 64'(bus.irq_o), 64'd0);
      m_hold = 0; m_ptr = 0; m_count = 0; m_ovf = 0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      m_cyc = 32'd1;
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   // Monitor: compares the held report against the scoreboard at each handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && bus.rpt_valid_o && bus.rpt_ready_i) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rpt_unexpected: got report from unit %0d, expected none", bus.rpt_unit_o);
            end else begin
               e = sb.pop_front();
               chk("rpt_unit", 64'(bus.rpt_unit_o), 64'(e.unit));
               chk("rpt_code", 64'(bus.rpt_code_o), 64'(e.e.code));
               chk("rpt_addr", 64'(bus.rpt_addr_o), 64'(e.e.addr));
               chk("rpt_meta", 64'(bus.rpt_meta_o), 64'(e.e.meta));
`ifdef BUS_ERR_ARB_TIMESTAMP_EN
               chk("rpt_time", 64'(bus.rpt_time_o), 64'(e.ts));
`else
               chk("rpt_time", 64'(bus.rpt_time_o), 64'd0);
`endif
            end
         end
      end
   end

   initial begin
      entry_t e;
      int unsigned exp_order[5] = '{0, 1, 2, 3, 0};
      ready_pct = 100; irq_pct = 0; clr_pct = 0; ovf_pct = 0; ovf_force = '0;
      stepno = 0;
      do_reset();

      // Single error from unit 2.
      e.code = 3'd3; e.addr = 48'h1000; e.meta = '0;
      fifo[2].push_back(e);
      run(4);

      // Fairness from ptr 0 with all units pending.
      do_reset();
      for (int u = 0; u < NU; u++) begin
         fifo[u].push_back(rand_entry());
         fifo[u].push_back(rand_entry());
      end
      glog_unit.delete(); glog_step.delete();
      run(12);
      for (int i = 0; i < 5; i++) begin
         if (i < glog_unit.size()) begin
            chk("fair_order", 64'(glog_unit[i]), 64'(exp_order[i]));
            if (i > 0) chk("fair_spacing", 64'(glog_step[i] - glog_step[i-1]), 64'd2);
         end else begin
            chk("fair_grants", 64'(glog_unit.size()), 64'd5);
         end
      end
      run(6);

      // Backpressure with another unit pending during the hold.
      fifo[1].push_back(rand_entry());
      ready_pct = 0;
      run(2);
      fifo[0].push_back(rand_entry());
      run(5);
      ready_pct = 100;
      run(6);

      // Saturation, then clear on a handshake cycle.
      irq_pct = 60;
      run(20);
      while (!m_hold) step();
      clr_pct = 100;
      run(1);
      clr_pct = 0;
      run(4);

      // Overflow pulse then clear with no report pending.
      irq_pct = 0;
      run(12);
      ovf_force = 4'b0010;
      run(1);
      ovf_force = '0;
      run(2);
      clr_pct = 100;
      run(1);
      clr_pct = 0;
      run(2);

      // Random mix.
      irq_pct = 30; ready_pct = 60; clr_pct = 5; ovf_pct = 3;
      run(400);

      // Reset while holding a report from unit 2 (ptr would be 3).
      irq_pct = 0; clr_pct = 0; ovf_pct = 0; ready_pct = 100;
      run(12);
      for (int u = 0; u < NU; u++) fifo[u].delete();
      fifo[2].push_back(rand_entry());
      ready_pct = 0;
      run(2);
      #2;
      do_reset();
      fifo[1].push_back(rand_entry());
      fifo[3].push_back(rand_entry());
      glog_unit.delete(); glog_step.delete();
      ready_pct = 100;
      run(6);
      chk("post_rst_first_grant", 64'(glog_unit.size() > 0 ? glog_unit[0] : 99), 64'd1);

      @(negedge clk);
      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
